// File: rtl/usb_utmi_tx_arb_if.sv
// Requester, UTMI transmit and status signals shared by the transmit arbiter and its environment.
// The arbiter connects through slave; requesters and the PHY side connect through master.
interface usb_utmi_tx_arb_if;
    logic [7:0] r0_data;
    logic       r0_valid;
    logic       r0_last;
    logic       r0_ready;
    logic [7:0] r1_data;
    logic       r1_valid;
    logic       r1_last;
    logic       r1_ready;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;
    logic       rx_active_i;
    logic [1:0] line_state_i;
    logic [1:0] grant_o;
    logic       busy_o;
    logic       done_o;
    logic       abort_o;

    modport slave (
        input  r0_data, r0_valid, r0_last, r1_data, r1_valid, r1_last,
        input  tx_ready_i, rx_active_i, line_state_i,
        output r0_ready, r1_ready, tx_data_o, tx_valid_o,
        output grant_o, busy_o, done_o, abort_o
    );

    modport master (
        output r0_data, r0_valid, r0_last, r1_data, r1_valid, r1_last,
        output tx_ready_i, rx_active_i, line_state_i,
        input  r0_ready, r1_ready, tx_data_o, tx_valid_o,
        input  grant_o, busy_o, done_o, abort_o
    );
endinterface

// File: rtl/usb_utmi_tx_arb.sv
// Round-robin scheduler sharing one UTMI transmitter between two packet sources,
// with line-idle gating, inter-packet gap, underrun abort and TxReady timeout.
module usb_utmi_tx_arb #(
    parameter int unsigned IPG_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [1:0]  IDLE_LINESTATE = 2'b01
) (
    input  logic               clk,
    input  logic               rst,
    usb_utmi_tx_arb_if.slave   bus
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] IPG_LAST = CNT_W'(IPG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             last_q, last_d;
    logic [1:0]       grant_q, grant_d;
    logic             prefer_q, prefer_d;
    logic             busy_q;
    logic             done_q, done_d;
    logic             abort_q, abort_d;
    logic             r0_ready_c, r1_ready_c;
    logic             win;
    logic             gnt1;
    logic             sel_valid, sel_last;
    logic [7:0]       sel_data;

    // Byte source of the current packet owner
    assign gnt1      = grant_q[1];
    assign sel_valid = gnt1 ? bus.r1_valid : bus.r0_valid;
    assign sel_last  = gnt1 ? bus.r1_last  : bus.r0_last;
    assign sel_data  = gnt1 ? bus.r1_data  : bus.r0_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            last_q     <= 1'b0;
            grant_q    <= 2'b00;
            prefer_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            prefer_q   <= prefer_d;
            busy_q     <= (state_d != IDLE);
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        last_d     = last_q;
        grant_d    = grant_q;
        prefer_d   = prefer_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        r0_ready_c = 1'b0;
        r1_ready_c = 1'b0;
        win        = 1'b0;
        case (state_q)
            IDLE: begin
                if ((bus.r0_valid | bus.r1_valid) && !bus.rx_active_i &&
                    (bus.line_state_i == IDLE_LINESTATE)) begin
                    // prefer_q names the requester not granted last
                    win        = (bus.r0_valid & bus.r1_valid) ? prefer_q : bus.r1_valid;
                    r0_ready_c = !win;
                    r1_ready_c = win;
                    tx_data_d  = win ? bus.r1_data : bus.r0_data;
                    last_d     = win ? bus.r1_last : bus.r0_last;
                    tx_valid_d = 1'b1;
                    grant_d    = win ? 2'b10 : 2'b01;
                    prefer_d   = !win;
                    cnt_d      = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (bus.tx_ready_i) begin
                    cnt_d = '0;
                    if (last_q) begin
                        done_d     = 1'b1;
                        tx_valid_d = 1'b0;
                        grant_d    = 2'b00;
                        state_d    = GAP;
                    end else if (sel_valid) begin
                        r0_ready_c = !gnt1;
                        r1_ready_c = gnt1;
                        tx_data_d  = sel_data;
                        last_d     = sel_last;
                    end else begin
                        abort_d    = 1'b1;
                        tx_valid_d = 1'b0;
                        grant_d    = 2'b00;
                        state_d    = GAP;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    abort_d    = 1'b1;
                    tx_valid_d = 1'b0;
                    grant_d    = 2'b00;
                    cnt_d      = '0;
                    state_d    = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == IPG_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // No byte may be consumed while the block is being reset
        if (rst) begin
            r0_ready_c = 1'b0;
            r1_ready_c = 1'b0;
        end
    end

    assign bus.r0_ready   = r0_ready_c;
    assign bus.r1_ready   = r1_ready_c;
    assign bus.tx_data_o  = tx_data_q;
    assign bus.tx_valid_o = tx_valid_q;
    assign bus.grant_o    = grant_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.abort_o    = abort_q;
endmodule

// File: tb/tb_usb_utmi_tx_arb.sv
// Directed bench for usb_utmi_tx_arb: single packet, round-robin order, rx/line gating,
// underrun, timeout and mid-packet reset.
module tb_usb_utmi_tx_arb;
    localparam int unsigned IPG = 5;
    localparam int unsigned TMO = 8;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    usb_utmi_tx_arb_if bus ();

    usb_utmi_tx_arb #(.IPG_CYCLES(IPG), .TIMEOUT_CYCLES(TMO), .IDLE_LINESTATE(2'b01)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy_o && n < 40) begin
            step;
            n++;
        end
        chk(tag, 8'(n < 40), 8'd1);
    endtask

    // One single-byte packet from whichever requester is expected to win
    task automatic pkt(input string tag, input logic [1:0] exp_g, input logic [7:0] exp_d);
        int n = 0;
        #1;
        while (!(bus.r0_ready | bus.r1_ready) && n < 40) begin
            step;
            n++;
        end
        chk({tag, "_rdy_wait"}, 8'(n < 40), 8'd1);
        chk({tag, "_rdy"}, 8'({bus.r1_ready, bus.r0_ready}), 8'(exp_g));
        step;
        if (exp_g[0]) bus.r0_valid = 1'b0;
        else          bus.r1_valid = 1'b0;
        #1;
        chk({tag, "_grant"}, 8'(bus.grant_o), 8'(exp_g));
        chk({tag, "_data"}, bus.tx_data_o, exp_d);
        chk({tag, "_valid"}, 8'(bus.tx_valid_o), 8'd1);
        chk({tag, "_rdy_send"}, 8'({bus.r1_ready, bus.r0_ready}), 8'd0);
        bus.tx_ready_i = 1'b1;
        step;
        bus.tx_ready_i = 1'b0;
        chk({tag, "_done"}, 8'(bus.done_o), 8'd1);
        wait_idle({tag, "_idle"});
    endtask

    logic [7:0] bytes [3];

    initial begin
        bytes = '{8'hC3, 8'h12, 8'h34};
        rst = 1'b1;
        bus.r0_data = '0; bus.r0_valid = 1'b0; bus.r0_last = 1'b0;
        bus.r1_data = '0; bus.r1_valid = 1'b0; bus.r1_last = 1'b0;
        bus.tx_ready_i = 1'b0; bus.rx_active_i = 1'b0; bus.line_state_i = 2'b01;
        step; step;
        chk("rst_valid", 8'(bus.tx_valid_o), 8'd0);
        chk("rst_data", bus.tx_data_o, 8'h00);
        chk("rst_grant", 8'(bus.grant_o), 8'd0);
        chk("rst_busy", 8'(bus.busy_o), 8'd0);
        chk("rst_done_abort", 8'({bus.done_o, bus.abort_o}), 8'd0);
        rst = 1'b0;

        // Single 3-byte packet, TxReady every 4th clock
        bus.r0_valid = 1'b1; bus.r0_data = bytes[0]; bus.r0_last = 1'b0;
        #1 chk("t1_rdy0", 8'(bus.r0_ready), 8'd1);
        step;
        chk("t1_grant", 8'(bus.grant_o), 8'd1);
        chk("t1_busy", 8'(bus.busy_o), 8'd1);
        for (int k = 0; k < 3; k++) begin
            chk("t1_data", bus.tx_data_o, bytes[k]);
            chk("t1_valid", 8'(bus.tx_valid_o), 8'd1);
            if (k < 2) begin
                bus.r0_data = bytes[k+1];
                bus.r0_last = (k == 1);
            end else begin
                bus.r0_valid = 1'b0;
                bus.r0_last  = 1'b0;
            end
            repeat (3) begin
                step;
                chk("t1_hold", bus.tx_data_o, bytes[k]);
                chk("t1_noready", 8'(bus.r0_ready), 8'd0);
            end
            bus.tx_ready_i = 1'b1;
            #1 chk("t1_rdy", 8'(bus.r0_ready), 8'(k < 2));
            step;
            bus.tx_ready_i = 1'b0;
        end
        chk("t1_valid_low", 8'(bus.tx_valid_o), 8'd0);
        chk("t1_done", 8'(bus.done_o), 8'd1);
        chk("t1_abort", 8'(bus.abort_o), 8'd0);
        chk("t1_grant_gap", 8'(bus.grant_o), 8'd0);
        step;
        chk("t1_done_width", 8'(bus.done_o), 8'd0);
        repeat (IPG - 2) step;
        chk("t1_busy_gap", 8'(bus.busy_o), 8'd1);
        step;
        chk("t1_busy_end", 8'(bus.busy_o), 8'd0);

        // Round robin: fresh reset, both valid -> r0, r1; r0 alone; both -> r1, r0
        rst = 1'b1; step; rst = 1'b0;
        bus.r0_last = 1'b1; bus.r1_last = 1'b1;
        bus.r0_valid = 1'b1; bus.r0_data = 8'hAA;
        bus.r1_valid = 1'b1; bus.r1_data = 8'hBB;
        pkt("rr1", 2'b01, 8'hAA);
        pkt("rr2", 2'b10, 8'hBB);
        bus.r0_valid = 1'b1; bus.r0_data = 8'hA1;
        pkt("rr3", 2'b01, 8'hA1);
        bus.r0_valid = 1'b1; bus.r0_data = 8'hA2;
        bus.r1_valid = 1'b1; bus.r1_data = 8'hB2;
        pkt("rr4", 2'b10, 8'hB2);
        pkt("rr5", 2'b01, 8'hA2);

        // Rx activity and non-idle line state block the grant
        bus.r1_valid = 1'b1; bus.r1_data = 8'h5A; bus.rx_active_i = 1'b1;
        repeat (3) begin
            step;
            chk("rx_valid", 8'(bus.tx_valid_o), 8'd0);
            chk("rx_ready", 8'(bus.r1_ready), 8'd0);
        end
        bus.rx_active_i = 1'b0; bus.line_state_i = 2'b00;
        step;
        chk("ls_ready", 8'(bus.r1_ready), 8'd0);
        chk("ls_valid", 8'(bus.tx_valid_o), 8'd0);
        bus.line_state_i = 2'b01;
        #1 chk("rx_fall_ready", 8'(bus.r1_ready), 8'd1);
        step;
        chk("rx_grant", 8'(bus.grant_o), 8'b10);
        chk("rx_txvalid", 8'(bus.tx_valid_o), 8'd1);
        bus.r1_valid = 1'b0;
        bus.tx_ready_i = 1'b1; step; bus.tx_ready_i = 1'b0;
        chk("rx_done", 8'(bus.done_o), 8'd1);
        wait_idle("rx_idle");

        // Underrun: first byte not last, requester then has nothing
        bus.r0_valid = 1'b1; bus.r0_data = 8'h4B; bus.r0_last = 1'b0;
        step;
        chk("ur_data", bus.tx_data_o, 8'h4B);
        bus.r0_valid = 1'b0; bus.tx_ready_i = 1'b1;
        #1 chk("ur_ready", 8'(bus.r0_ready), 8'd0);
        step;
        bus.tx_ready_i = 1'b0;
        chk("ur_abort", 8'(bus.abort_o), 8'd1);
        chk("ur_done", 8'(bus.done_o), 8'd0);
        chk("ur_valid", 8'(bus.tx_valid_o), 8'd0);
        chk("ur_busy", 8'(bus.busy_o), 8'd1);
        step;
        chk("ur_abort_width", 8'(bus.abort_o), 8'd0);
        wait_idle("ur_idle");

        // Timeout: TxReady never comes
        bus.r0_valid = 1'b1; bus.r0_data = 8'h4C; bus.r0_last = 1'b0;
        step;
        chk("to_valid_up", 8'(bus.tx_valid_o), 8'd1);
        bus.r0_data = 8'h4D;
        repeat (TMO - 1) step;
        chk("to_early", 8'({bus.tx_valid_o, bus.abort_o}), 8'b10);
        step;
        chk("to_abort", 8'(bus.abort_o), 8'd1);
        chk("to_valid_low", 8'(bus.tx_valid_o), 8'd0);
        chk("to_done", 8'(bus.done_o), 8'd0);
        bus.r0_valid = 1'b0;
        step;
        chk("to_abort_width", 8'(bus.abort_o), 8'd0);
        wait_idle("to_idle");

        // Reset during byte 2, then r0 preferred again
        bus.r1_valid = 1'b1; bus.r1_data = 8'h77; bus.r1_last = 1'b1;
        pkt("pre", 2'b10, 8'h77);
        bus.r0_valid = 1'b1; bus.r0_data = 8'h11; bus.r0_last = 1'b0;
        step;
        bus.r0_data = 8'h22;
        bus.tx_ready_i = 1'b1; step; bus.tx_ready_i = 1'b0;
        chk("mr_byte2", bus.tx_data_o, 8'h22);
        bus.r0_data = 8'h33; rst = 1'b1;
        #1 chk("mr_ready_in_rst", 8'(bus.r0_ready), 8'd0);
        step;
        chk("mr_valid", 8'(bus.tx_valid_o), 8'd0);
        chk("mr_data", bus.tx_data_o, 8'h00);
        chk("mr_grant", 8'(bus.grant_o), 8'd0);
        chk("mr_busy", 8'(bus.busy_o), 8'd0);
        chk("mr_pulses", 8'({bus.done_o, bus.abort_o}), 8'd0);
        rst = 1'b0;
        bus.r0_data = 8'hE0; bus.r0_last = 1'b1;
        bus.r1_valid = 1'b1; bus.r1_data = 8'hE1;
        pkt("mr_after0", 2'b01, 8'hE0);
        pkt("mr_after1", 2'b10, 8'hE1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
